// File: rtl/control_seq.sv
// Sequencing control unit: same-cycle decode of simple opcodes plus multi-cycle
// read / accelerator / write sequences for encrypt, decrypt and FFT, with timeout and sticky halt.
module control_seq #(
    parameter int OPCODE_W    = 4,
    parameter int TIMEOUT_W   = 8,
    parameter int ACC_TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                program_end,
    input  logic                acc_done,
    output logic                regwrite,
    output logic                alu_use,
    output logic                jump_en,
    output logic                branch_en,
    output logic                call_en,
    output logic                ret_en,
    output logic                mem_read,
    output logic                mem_write,
    output logic                acc_start,
    output logic [1:0]          acc_sel,
    output logic                stall,
    output logic                busy,
    output logic                halted,
    output logic                timeout_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(ACC_TIMEOUT - 1);

    logic [2:0]           state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [1:0]           acc_sel_q;
    logic                 end_pend;
    logic [1:0]           dec_sel;
    logic                 is_acc_op;

    always_comb begin
        dec_sel = 2'b00;
        case (opcode)
            OPCODE_W'(9):  dec_sel = 2'b01;
            OPCODE_W'(10): dec_sel = 2'b10;
            OPCODE_W'(11): dec_sel = 2'b11;
            default:       dec_sel = 2'b00;
        endcase
        is_acc_op = (dec_sel != 2'b00);
    end

    // Outputs are forced low while rst is held so an async abort is visible in the same cycle
    always_comb begin
        regwrite  = 1'b0;
        alu_use   = 1'b0;
        jump_en   = 1'b0;
        branch_en = 1'b0;
        call_en   = 1'b0;
        ret_en    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        acc_start = 1'b0;
        acc_sel   = 2'b00;
        stall     = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (instr_valid && !program_end) begin
                        case (opcode)
                            OPCODE_W'(1), OPCODE_W'(2): begin
                                regwrite = 1'b1;
                                alu_use  = 1'b1;
                            end
                            OPCODE_W'(3): jump_en   = 1'b1;
                            OPCODE_W'(4): branch_en = 1'b1;
                            OPCODE_W'(5): begin
                                regwrite = 1'b1;
                                mem_read = 1'b1;
                            end
                            OPCODE_W'(6): mem_write = 1'b1;
                            OPCODE_W'(7): call_en   = 1'b1;
                            OPCODE_W'(8): ret_en    = 1'b1;
                            default:      stall     = is_acc_op;
                        endcase
                    end
                end
                S_RD: begin
                    mem_read  = 1'b1;
                    acc_start = 1'b1;
                    stall     = 1'b1;
                    busy      = 1'b1;
                    acc_sel   = acc_sel_q;
                end
                S_RUN: begin
                    stall   = 1'b1;
                    busy    = 1'b1;
                    acc_sel = acc_sel_q;
                end
                S_WR: begin
                    mem_write = 1'b1;
                    stall     = 1'b1;
                    busy      = 1'b1;
                    acc_sel   = acc_sel_q;
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

    // A program_end seen mid-sequence is remembered so the halt happens once the sequence ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            acc_sel_q   <= 2'b00;
            end_pend    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (program_end) begin
                        state <= S_HALT;
                    end else if (instr_valid && is_acc_op) begin
                        state     <= S_RD;
                        acc_sel_q <= dec_sel;
                    end
                end
                S_RD: begin
                    wait_cnt <= '0;
                    state    <= S_RUN;
                    if (program_end) end_pend <= 1'b1;
                end
                S_RUN: begin
                    if (program_end) end_pend <= 1'b1;
                    wait_cnt <= wait_cnt + 1'b1;
                    if (acc_done) begin
                        state <= S_WR;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        acc_sel_q   <= 2'b00;
                        if (end_pend || program_end) begin
                            state <= S_HALT;
                        end else begin
                            state    <= S_IDLE;
                            end_pend <= 1'b0;
                        end
                    end
                end
                S_WR: begin
                    acc_sel_q <= 2'b00;
                    if (end_pend || program_end) begin
                        state <= S_HALT;
                    end else begin
                        state    <= S_IDLE;
                        end_pend <= 1'b0;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
